// File: rtl/acc_cpu_pkg.sv
// ---------------------------------------------------------------------------
// acc_cpu_pkg
// Shared definitions for the multicycle accumulator CPU (acc_cpu_mc):
//   - 4-bit opcode encodings (top nibble of every instruction word)
//   - FSM state encodings
//   - HALT opcode, present only when ACC_CPU_HALT_EN is defined
//   - helper predicates used by the decoder
// ---------------------------------------------------------------------------
package acc_cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDAC = 4'h1;
    localparam logic [3:0] OP_STAC = 4'h2;
    localparam logic [3:0] OP_MVAC = 4'h3;
    localparam logic [3:0] OP_MOVR = 4'h4;
    localparam logic [3:0] OP_JUMP = 4'h5;
    localparam logic [3:0] OP_JMPZ = 4'h6;
    localparam logic [3:0] OP_JPNZ = 4'h7;
    localparam logic [3:0] OP_ADD  = 4'h8;
    localparam logic [3:0] OP_SUB  = 4'h9;
    localparam logic [3:0] OP_INAC = 4'hA;
    localparam logic [3:0] OP_CLAC = 4'hB;
    localparam logic [3:0] OP_AND  = 4'hC;
    localparam logic [3:0] OP_OR   = 4'hD;
    localparam logic [3:0] OP_XOR  = 4'hE;
    localparam logic [3:0] OP_NOT  = 4'hF;

`ifdef ACC_CPU_HALT_EN
    // HALT shares the NOP opcode; it is the NOP word whose low bits are all 1.
    localparam logic [3:0] OP_HALT = OP_NOP;
`endif

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_OPER   = 3'd3,
        S_MEM    = 3'd4,
        S_EXEC   = 3'd5
`ifdef ACC_CPU_HALT_EN
        ,
        S_HALT   = 3'd6
`endif
    } state_t;

    // Instructions that carry an address word after the opcode word.
    function automatic logic needs_operand(input logic [3:0] op);
        return (op == OP_LDAC) || (op == OP_STAC) || (op == OP_JUMP) ||
               (op == OP_JMPZ) || (op == OP_JPNZ);
    endfunction

    // Instructions that go on to a data transfer after the address word.
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LDAC) || (op == OP_STAC);
    endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// ---------------------------------------------------------------------------
// acc_cpu_alu
// Combinational ALU for the accumulator CPU. Handles opcodes 8-F; any other
// opcode passes a through unchanged.
// Ports:
//   a      in  DATA_W  accumulator operand
//   b      in  DATA_W  R register operand
//   op     in  4       instruction opcode
//   result out DATA_W  result, modulo 2**DATA_W, no carry out
//   zero   out 1       result == 0
// ---------------------------------------------------------------------------
module acc_cpu_alu
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        op,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    always_comb begin
        result = a;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_INAC: result = a + DATA_W'(1);
            OP_CLAC: result = '0;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOT:  result = ~a;
            default: result = a;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/acc_cpu_mc.sv
// ---------------------------------------------------------------------------
// acc_cpu_mc
// Multicycle accumulator CPU core (AC, R, Z, PC, IR, AR) with a single shared
// instruction/data memory port using a req/ack handshake.
//
// Handshake: a transfer starts when mem_req rises (or on the cycle after an
// ack while mem_req stays high). mem_addr/mem_we/mem_wdata are held stable
// while mem_req=1 and mem_ack=0. A cycle with mem_req=1 and mem_ack=1 ends
// exactly one transfer, and mem_rdata is sampled only on that cycle. mem_ack
// is ignored while mem_req=0.
//
// Optional feature macro: ACC_CPU_HALT_EN. When defined, the word with
// opcode 0 and all low DATA_W-4 bits set is HALT: the core parks in S_HALT,
// raises halted and issues no further requests until reset. When undefined
// that word is an ordinary NOP and halted is tied low.
//
// Ports:
//   clk        in   1       clock, rising edge
//   reset      in   1       asynchronous active-high reset
//   mem_req    out  1       memory transfer request
//   mem_we     out  1       1=write, 0=read
//   mem_addr   out  ADDR_W  transfer address
//   mem_wdata  out  DATA_W  write data (AC)
//   mem_rdata  in   DATA_W  read data
//   mem_ack    in   1       transfer complete this cycle
//   dbg_pc     out  ADDR_W  current PC
//   dbg_ac     out  DATA_W  current AC
//   dbg_z      out  1       current Z flag
//   halted     out  1       core stopped
// ---------------------------------------------------------------------------
module acc_cpu_mc
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] dbg_pc,
    output logic [DATA_W-1:0] dbg_ac,
    output logic              dbg_z,
    output logic              halted
);

    // Only the opcode nibble of IR matters unless HALT decoding needs the
    // low bits as well.
`ifdef ACC_CPU_HALT_EN
    localparam int IR_W = DATA_W;
`else
    localparam int IR_W = 4;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ar_q, ar_d;
    logic [IR_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0] ac_q, ac_d;
    logic [DATA_W-1:0] r_q, r_d;
    logic              z_q, z_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
`ifdef ACC_CPU_HALT_EN
    logic              halted_q, halted_d;
    logic              halt_low_ones;
`endif

    logic [3:0]        opcode;
    logic              xfer;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;

    assign opcode = ir_q[IR_W-1 -: 4];
    assign xfer   = req_q & mem_ack;

    acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (ac_q),
        .b      (r_q),
        .op     (opcode),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // Next-state logic. Memory-port outputs are registered, so each branch
    // that enters a requesting state also sets up the address it will use.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ar_d    = ar_q;
        ir_d    = ir_q;
        ac_d    = ac_q;
        r_d     = r_q;
        z_d     = z_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
`ifdef ACC_CPU_HALT_EN
        halted_d      = halted_q;
        halt_low_ones = 1'b1;
        for (int i = 0; i < DATA_W - 4; i++) begin
            halt_low_ones = halt_low_ones & ir_q[i];
        end
`endif

        case (state_q)
            S_RST: begin
                state_d = S_FETCH;
                req_d   = 1'b1;
                we_d    = 1'b0;
                addr_d  = pc_q;
            end

            S_FETCH: begin
                if (xfer) begin
                    ir_d    = mem_rdata[DATA_W-1 -: IR_W];
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_DECODE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                end
            end

            S_DECODE: begin
                if (needs_operand(opcode)) begin
                    state_d = S_OPER;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = pc_q;
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_OPER: begin
                if (xfer) begin
                    ar_d = mem_rdata[ADDR_W-1:0];
                    pc_d = pc_q + ADDR_W'(1);
                    if (is_mem_op(opcode)) begin
                        // req stays high; the data transfer follows directly.
                        state_d = S_MEM;
                        req_d   = 1'b1;
                        we_d    = (opcode == OP_STAC);
                        addr_d  = mem_rdata[ADDR_W-1:0];
                    end else begin
                        state_d = S_EXEC;
                        req_d   = 1'b0;
                        we_d    = 1'b0;
                    end
                end
            end

            S_MEM: begin
                if (xfer) begin
                    if (opcode == OP_LDAC) begin
                        ac_d = mem_rdata;
                    end
                    state_d = S_FETCH;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = pc_q;
                end
            end

            S_EXEC: begin
                case (opcode)
                    OP_MVAC: r_d  = ac_q;
                    OP_MOVR: ac_d = r_q;
                    OP_JUMP: pc_d = ar_q;
                    OP_JMPZ: if (z_q)  pc_d = ar_q;
                    OP_JPNZ: if (!z_q) pc_d = ar_q;
                    default: begin
                        // Opcodes 8-F are the ALU group; only they touch Z.
                        if (opcode[3]) begin
                            ac_d = alu_result;
                            z_d  = alu_zero;
                        end
                    end
                endcase
                state_d = S_FETCH;
                req_d   = 1'b1;
                we_d    = 1'b0;
                addr_d  = pc_d;
`ifdef ACC_CPU_HALT_EN
                if ((opcode == OP_HALT) && halt_low_ones) begin
                    state_d  = S_HALT;
                    req_d    = 1'b0;
                    halted_d = 1'b1;
                end
`endif
            end

`ifdef ACC_CPU_HALT_EN
            S_HALT: begin
                state_d = S_HALT;
                req_d   = 1'b0;
                we_d    = 1'b0;
            end
`endif

            default: begin
                state_d = S_RST;
                req_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    // Asynchronous reset clears req immediately, aborting any transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_RST;
            pc_q     <= ADDR_W'(RESET_PC);
            ar_q     <= '0;
            ir_q     <= '0;
            ac_q     <= '0;
            r_q      <= '0;
            z_q      <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
`ifdef ACC_CPU_HALT_EN
            halted_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ar_q     <= ar_d;
            ir_q     <= ir_d;
            ac_q     <= ac_d;
            r_q      <= r_d;
            z_q      <= z_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
`ifdef ACC_CPU_HALT_EN
            halted_q <= halted_d;
`endif
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = ac_q;
    assign dbg_pc    = pc_q;
    assign dbg_ac    = ac_q;
    assign dbg_z     = z_q;
`ifdef ACC_CPU_HALT_EN
    assign halted    = halted_q;
`else
    assign halted    = 1'b0;
`endif

endmodule

// File: tb/tb_acc_cpu_mc.sv
// ---------------------------------------------------------------------------
// tb_acc_cpu_mc
// Bench for acc_cpu_mc (DATA_W=8, ADDR_W=8, RESET_PC=0). A unified memory
// model with a programmable wait count answers the core's requests and
// raises random ack noise while no request is pending. Each program ends in a
// self-jump; the run stops when the core starts fetching that address for the
// n-th time. An instruction-level model of the ISA predicts the final AC, Z,
// memory image and cycle count for the same program.
// ---------------------------------------------------------------------------
module tb_acc_cpu_mc;

    logic       clk = 1'b0;
    logic       reset;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ack;
    logic [7:0] dbg_pc;
    logic [7:0] dbg_ac;
    logic       dbg_z;
    logic       halted;

    always #5 clk = ~clk;

    acc_cpu_mc #(.DATA_W(8), .ADDR_W(8), .RESET_PC(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .dbg_pc    (dbg_pc),
        .dbg_ac    (dbg_ac),
        .dbg_z     (dbg_z),
        .halted    (halted)
    );

    // ---------------- memory model ----------------
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    int         wait_cycles = 0;
    int         wcnt = 0;
    logic       ack_noise = 1'b0;

    assign mem_rdata = mem[mem_addr];
    assign mem_ack   = mem_req ? (wcnt == wait_cycles) : ack_noise;

    always @(posedge clk) begin
        ack_noise <= 1'($urandom_range(0, 1));
        if (mem_req && mem_ack) begin
            if (mem_we) mem[mem_addr] = mem_wdata;
            wcnt <= 0;
        end else if (mem_req) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] exp_ac, exp_pc;
    logic       exp_z;
    int         exp_cyc;

    task automatic model_run(input logic [7:0] loop_addr, input int n_arr, input int w);
        logic [7:0] pc, ac, r, ir, a;
        logic       z;
        logic [3:0] op;
        int         cyc, arr;
        pc = 8'h00; ac = 8'h00; r = 8'h00; z = 1'b0; cyc = 0; arr = 0;
        for (int step = 0; step < 2000; step++) begin
            if (pc == loop_addr) begin
                arr++;
                if (arr == n_arr) break;
            end
            ir = ref_mem[pc];
            pc = pc + 8'd1;
            op = ir[7:4];
            if (op inside {4'h1, 4'h2, 4'h5, 4'h6, 4'h7}) begin
                a  = ref_mem[pc];
                pc = pc + 8'd1;
                if (op == 4'h1 || op == 4'h2) cyc += 4 + 3 * w;
                else                          cyc += 4 + 2 * w;
                case (op)
                    4'h1: ac = ref_mem[a];
                    4'h2: ref_mem[a] = ac;
                    4'h5: pc = a;
                    4'h6: if (z)  pc = a;
                    default: if (!z) pc = a;
                endcase
            end else begin
                cyc += 3 + w;
                case (op)
                    4'h3: r  = ac;
                    4'h4: ac = r;
                    4'h8: ac = ac + r;
                    4'h9: ac = ac - r;
                    4'hA: ac = ac + 8'd1;
                    4'hB: ac = 8'h00;
                    4'hC: ac = ac & r;
                    4'hD: ac = ac | r;
                    4'hE: ac = ac ^ r;
                    4'hF: ac = ~ac;
                    default: ;
                endcase
                if (op >= 4'h8) z = (ac == 8'h00);
            end
        end
        exp_ac = ac; exp_z = z; exp_pc = pc; exp_cyc = cyc;
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic do_reset(input string name);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq({name, "_rst_req"}, 32'(mem_req), 32'd0);
        check_eq({name, "_rst_pc"}, 32'(dbg_pc), 32'h00);
        check_eq({name, "_rst_ac"}, 32'(dbg_ac), 32'h00);
        check_eq({name, "_rst_z"}, 32'(dbg_z), 32'd0);
        check_eq({name, "_rst_halted"}, 32'(halted), 32'd0);
        reset = 1'b0;
    endtask

    logic [7:0] got_ac, got_pc;
    logic       got_z;

    task automatic run_prog(input string name, input logic [7:0] loop_addr, input int n_arr, input int w);
        logic       prev_req, prev_ack, new_x, done, lat_we;
        logic [7:0] lat_addr, lat_wd;
        int         first, arr, got_cyc, stab, nmis;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        model_run(loop_addr, n_arr, w);
        wait_cycles = w;
        do_reset(name);
        prev_req = 1'b0; prev_ack = 1'b0; done = 1'b0;
        lat_we = 1'b0; lat_addr = 8'h00; lat_wd = 8'h00;
        first = -1; arr = 0; got_cyc = -1; stab = 0;
        got_ac = 8'hxx; got_pc = 8'hxx; got_z = 1'bx;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                check_eq({name, "_first_req"}, 32'(mem_req), 32'd1);
                check_eq({name, "_first_addr"}, 32'(mem_addr), 32'h00);
            end
            new_x = mem_req && (!prev_req || prev_ack);
            if (new_x) begin
                lat_addr = mem_addr; lat_we = mem_we; lat_wd = mem_wdata;
                if (first < 0) first = cyc;
                if (mem_addr == loop_addr && !mem_we) begin
                    arr++;
                    if (arr == n_arr) begin
                        done    = 1'b1;
                        got_cyc = cyc - first;
                        got_ac  = dbg_ac;
                        got_z   = dbg_z;
                        got_pc  = dbg_pc;
                    end
                end
            end else if (mem_req) begin
                if (mem_addr !== lat_addr || mem_we !== lat_we || (mem_we && mem_wdata !== lat_wd))
                    stab++;
            end
            prev_req = mem_req;
            prev_ack = mem_ack;
        end
        check_eq({name, "_done"}, 32'(done), 32'd1);
        check_eq({name, "_ac"}, 32'(got_ac), 32'(exp_ac));
        check_eq({name, "_z"}, 32'(got_z), 32'(exp_z));
        check_eq({name, "_pc"}, 32'(got_pc), 32'(exp_pc));
        check_eq({name, "_cycles"}, 32'(got_cyc), 32'(exp_cyc));
        check_eq({name, "_stable"}, 32'(stab), 32'd0);
        check_eq({name, "_halted"}, 32'(halted), 32'd0);
        nmis = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nmis++;
        check_eq({name, "_mem"}, 32'(nmis), 32'd0);
    endtask

    task automatic load_sum_prog();
        clear_mem();
        mem[8'h10] = 8'h37; mem[8'h11] = 8'h1D;
        mem[0] = 8'h10; mem[1] = 8'h10;   // LDAC 10
        mem[2] = 8'h30;                   // MVAC
        mem[3] = 8'h10; mem[4] = 8'h11;   // LDAC 11
        mem[5] = 8'h80;                   // ADD
        mem[6] = 8'h20; mem[7] = 8'h12;   // STAC 12
        mem[8] = 8'h50; mem[9] = 8'h08;   // JUMP 08
    endtask

    // Straight-line random program; jumps only skip one single-word instruction.
    task automatic gen_random(output logic [7:0] loop_addr);
        logic [7:0] p;
        logic [3:0] op, op2;
        clear_mem();
        for (int i = 8'h80; i < 8'h90; i++) mem[i] = 8'($urandom_range(0, 255));
        p = 8'h00;
        for (int k = 0; k < 18; k++) begin
            op = 4'($urandom_range(0, 15));
            if (op inside {4'h5, 4'h6, 4'h7}) begin
                op2 = 4'($urandom_range(3, 15));
                if (op2 inside {4'h5, 4'h6, 4'h7}) op2 = 4'hA;
                mem[p]            = {op, 4'h0};
                mem[p + 8'd1]     = p + 8'd3;
                mem[p + 8'd2]     = {op2, 4'($urandom_range(0, 15))};
                p = p + 8'd3;
            end else if (op == 4'h1 || op == 4'h2) begin
                mem[p]        = {op, 4'h0};
                mem[p + 8'd1] = 8'h80 + 8'($urandom_range(0, 15));
                p = p + 8'd2;
            end else begin
                mem[p] = (op == 4'h0) ? 8'h00 : {op, 4'($urandom_range(0, 15))};
                p = p + 8'd1;
            end
        end
        mem[p] = 8'h50; mem[p + 8'd1] = p;
        loop_addr = p;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] loop_addr;
        logic       found;
        reset = 1'b1;

        // Sum program, zero wait states.
        load_sum_prog();
        run_prog("sum0", 8'h08, 1, 0);
        check_eq("sum0_mem12", 32'(mem[8'h12]), 32'h54);
        check_eq("sum0_ac_const", 32'(got_ac), 32'h54);
        check_eq("sum0_z_const", 32'(got_z), 32'd0);

        // Same program with ack delayed 3 cycles on every transfer.
        load_sum_prog();
        run_prog("sum3", 8'h08, 1, 3);
        check_eq("sum3_mem12", 32'(mem[8'h12]), 32'h54);
        check_eq("sum3_ac_const", 32'(got_ac), 32'h54);

        // Conditional jumps.
        clear_mem();
        mem[8'h00] = 8'hB0;                       // CLAC
        mem[8'h01] = 8'h60; mem[8'h02] = 8'h40;   // JMPZ 40 (taken)
        mem[8'h40] = 8'hA0;                       // INAC
        mem[8'h41] = 8'h70; mem[8'h42] = 8'h50;   // JPNZ 50 (taken)
        mem[8'h50] = 8'hB0;                       // CLAC
        mem[8'h51] = 8'h70; mem[8'h52] = 8'h60;   // JPNZ 60 (not taken)
        mem[8'h53] = 8'h50; mem[8'h54] = 8'h53;   // JUMP 53
        run_prog("jmp", 8'h53, 1, 1);
        check_eq("jmp_pc_const", 32'(got_pc), 32'h53);
        check_eq("jmp_z_const", 32'(got_z), 32'd1);

        // PC wrap from 0xFF and INAC overflow to zero.
        clear_mem();
        mem[8'hF0] = 8'hFF;
        mem[8'h00] = 8'h10; mem[8'h01] = 8'hF0;   // LDAC F0
        mem[8'h02] = 8'h50; mem[8'h03] = 8'hFF;   // JUMP FF
        mem[8'hFF] = 8'hA0;                       // INAC, then fetch wraps to 00
        run_prog("wrap", 8'h00, 2, 0);
        check_eq("wrap_ac_const", 32'(got_ac), 32'h00);
        check_eq("wrap_z_const", 32'(got_z), 32'd1);
        check_eq("wrap_cycles_const", 32'(exp_cyc), 32'd11);

        // Random programs.
        for (int t = 0; t < 4; t++) begin
            gen_random(loop_addr);
            run_prog($sformatf("rnd%0d", t), loop_addr, 1, (t % 2) * 2);
        end

        // Reset asserted during the STAC data transfer.
        clear_mem();
        mem[8'h10] = 8'h37; mem[8'h20] = 8'hAA;
        mem[0] = 8'h10; mem[1] = 8'h10;           // LDAC 10
        mem[2] = 8'h20; mem[3] = 8'h20;           // STAC 20
        mem[4] = 8'h50; mem[5] = 8'h04;           // JUMP 04
        wait_cycles = 3;
        do_reset("midrst");
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (mem_req && mem_we) found = 1'b1;
        end
        check_eq("midrst_found_write", 32'(found), 32'd1);
        #1 reset = 1'b1;
        #1 check_eq("midrst_req_drop", 32'(mem_req), 32'd0);
        repeat (3) @(posedge clk);
        #1 check_eq("midrst_mem20", 32'(mem[8'h20]), 32'hAA);

`ifdef ACC_CPU_HALT_EN
        clear_mem();
        mem[0] = 8'hA0;                           // INAC
        mem[1] = 8'h0F;                           // HALT
        wait_cycles = 0;
        do_reset("halt");
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (halted) found = 1'b1;
        end
        check_eq("halt_halted", 32'(found), 32'd1);
        check_eq("halt_pc", 32'(dbg_pc), 32'h02);
        check_eq("halt_ac", 32'(dbg_ac), 32'h01);
        begin
            int nreq;
            nreq = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (mem_req) nreq++;
            end
            check_eq("halt_no_req", 32'(nreq), 32'd0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
